// File: rtl/param_dual_port_mem.sv
// rtl/param_dual_port_mem.sv - dual-port RAM with registered reads and a sweep-clear engine
// Port A wins same-address dual writes; RDW_MODE selects old or new data on read-during-write.
module param_dual_port_mem #(
  parameter int                DATA_W         = 16,
  parameter int                ADDR_W         = 10,
  parameter int                RDW_MODE       = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0,
  parameter int                CLEAR_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic              wren_a,
  input  logic              wren_b,
  input  logic              clear,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b,
  output logic              busy,
  output logic              collision
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_init_pend;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q_a;
  logic [DATA_W-1:0] r_q_b;
  logic              r_collision;

  logic              w_busy;
  logic              w_last;
  logic              w_same_addr;
  logic              w_wr_a;
  logic              w_wr_b;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  assign w_last      = (r_clr_addr == {ADDR_W{1'b1}});
  assign w_same_addr = (address_a == address_b);
  assign w_wr_a      = wren_a & ~w_busy;
  // B is dropped on a same-address dual write so port A's word is the one stored.
  assign w_wr_b      = wren_b & ~w_busy & ~(wren_a & w_same_addr);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_clr_addr  <= '0;
      r_init_pend <= (CLEAR_ON_RESET != 0);
    end else begin
      r_state     <= w_next_state;
      r_init_pend <= 1'b0;
      if (r_state == CLEAR) begin
        r_clr_addr <= w_last ? '0 : r_clr_addr + 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (clear || r_init_pend) begin
          w_next_state = CLEAR;
        end
      end
      CLEAR: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_busy) begin
      r_mem[r_clr_addr] <= CLEAR_VAL;
    end else begin
      if (w_wr_b) r_mem[address_b] <= data_b;
      if (w_wr_a) r_mem[address_a] <= data_a;
    end
  end

  // New-data mode forwards the word being stored this edge instead of the array contents.
  always_comb begin
    w_rd_a = r_mem[address_a];
    w_rd_b = r_mem[address_b];
    if (RDW_MODE != 0) begin
      if (w_wr_b && w_same_addr) w_rd_a = data_b;
      if (w_wr_a)                w_rd_a = data_a;
      if (w_wr_b)                w_rd_b = data_b;
      if (w_wr_a && w_same_addr) w_rd_b = data_a;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q_a       <= '0;
      r_q_b       <= '0;
      r_collision <= 1'b0;
    end else begin
      r_collision <= ~w_busy & wren_a & wren_b & w_same_addr;
      if (!w_busy) begin
        r_q_a <= w_rd_a;
        r_q_b <= w_rd_b;
      end
    end
  end

  assign q_a       = r_q_a;
  assign q_b       = r_q_b;
  assign busy      = w_busy;
  assign collision = r_collision;

endmodule

// File: tb/tb_param_dual_port_mem.sv
// tb/tb_param_dual_port_mem.sv - bench for param_dual_port_mem, old-data and new-data instances side by side
module tb_param_dual_port_mem;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b1;
  logic [DW-1:0] data_a  = '0;
  logic [DW-1:0] data_b  = '0;
  logic [AW-1:0] address_a = '0;
  logic [AW-1:0] address_b = '0;
  logic          wren_a  = 1'b0;
  logic          wren_b  = 1'b0;
  logic          clear   = 1'b0;

  logic [DW-1:0] q_a0, q_b0, q_a1, q_b1;
  logic          busy0, busy1, coll0, coll1;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: array contents, remaining sweep cycles, pending reset sweep
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left = 0;
  int            m_idx  = 0;
  bit            m_pend = 1'b0;
  logic [DW-1:0] e_qa0 = '0, e_qb0 = '0, e_qa1 = '0, e_qb1 = '0;
  logic          e_busy = 1'b0, e_coll = 1'b0;

  always #5 clock = ~clock;

  param_dual_port_mem #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .data_a(data_a), .data_b(data_b),
    .address_a(address_a), .address_b(address_b), .wren_a(wren_a), .wren_b(wren_b),
    .clear(clear), .q_a(q_a0), .q_b(q_b0), .busy(busy0), .collision(coll0)
  );

  param_dual_port_mem #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .data_a(data_a), .data_b(data_b),
    .address_a(address_a), .address_b(address_b), .wren_a(wren_a), .wren_b(wren_b),
    .clear(clear), .q_a(q_a1), .q_b(q_b1), .busy(busy1), .collision(coll1)
  );

  task automatic drive(input logic wa, input int aa, input int da,
                       input logic wb, input int ab, input int db);
    wren_a = wa; address_a = AW'(aa); data_a = DW'(da);
    wren_b = wb; address_b = AW'(ab); data_b = DW'(db);
  endtask

  // Advance the model by one edge using the present inputs, then let the DUTs take the edge.
  task automatic tick();
    if (m_left > 0) begin
      m_mem[m_idx] = '0;
      m_idx++;
      m_left--;
      e_coll = 1'b0;
    end else begin
      e_qa0 = m_mem[address_a];
      e_qb0 = m_mem[address_b];
      if (wren_b) m_mem[address_b] = data_b;
      if (wren_a) m_mem[address_a] = data_a;
      e_qa1 = m_mem[address_a];
      e_qb1 = m_mem[address_b];
      e_coll = wren_a && wren_b && (address_a == address_b);
      if (clear || m_pend) begin
        m_left = DEPTH;
        m_idx  = 0;
      end
    end
    m_pend = 1'b0;
    e_busy = (m_left > 0);
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_left = 0; m_idx = 0; m_pend = 1'b1;
    e_qa0 = '0; e_qb0 = '0; e_qa1 = '0; e_qb1 = '0; e_busy = 1'b0; e_coll = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({q_a0, q_b0, q_a1, q_b1} !== '0 || {busy0, busy1, coll0, coll1} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got qa=%h qb=%h qa1=%h qb1=%h busy=%b%b coll=%b%b expected all 0",
               q_a0, q_b0, q_a1, q_b1, busy0, busy1, coll0, coll1);
    end
    @(posedge clock);
    @(posedge clock);
    #3 reset_n = 1'b1;
    model_reset();
    tick();
    n_checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_sweep_start got busy=%b%b expected 11", busy0, busy1);
    end
    cnt = 1;
    for (int c = 0; c < 1030; c++) begin
      tick();
      n_checks++;
      if (busy0 !== e_busy || busy1 !== e_busy) begin
        n_fail++;
        $display("FAIL reset_sweep_busy cycle %0d got %b%b expected %b", c, busy0, busy1, e_busy);
      end
      if (busy0) cnt++;
    end
    n_checks++;
    if (cnt != DEPTH) begin
      n_fail++;
      $display("FAIL reset_sweep_len got %0d expected %0d", cnt, DEPTH);
    end
  endtask

  task automatic test_basic();
    drive(1, 0, 16'h000F, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (q_b0 !== 16'd15 || q_b1 !== 16'd15) begin
      n_fail++;
      $display("FAIL basic_read got %0d/%0d expected 15", q_b0, q_b1);
    end
  endtask

  task automatic test_dual_write();
    drive(1, 2, 5, 1, 1, 7);
    tick();
    n_checks++;
    if (coll0 !== 1'b0 || coll1 !== 1'b0) begin
      n_fail++;
      $display("FAIL dual_write_coll got %b%b expected 00", coll0, coll1);
    end
    drive(0, 1, 0, 0, 2, 0);
    tick();
    n_checks++;
    if (q_a0 !== 16'd7 || q_a1 !== 16'd7 || q_b0 !== 16'd5 || q_b1 !== 16'd5) begin
      n_fail++;
      $display("FAIL dual_write_read got a=%0d/%0d b=%0d/%0d expected a=7 b=5", q_a0, q_a1, q_b0, q_b1);
    end
  endtask

  task automatic test_collision();
    drive(1, 4, 8, 1, 4, 9);
    tick();
    n_checks++;
    if (coll0 !== 1'b1 || coll1 !== 1'b1) begin
      n_fail++;
      $display("FAIL collision_flag got %b%b expected 11", coll0, coll1);
    end
    drive(0, 4, 0, 0, 4, 0);
    tick();
    n_checks++;
    if (coll0 !== 1'b0 || coll1 !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_one_cycle got %b%b expected 00", coll0, coll1);
    end
    n_checks++;
    if (q_a0 !== 16'd8 || q_b0 !== 16'd8 || q_a1 !== 16'd8 || q_b1 !== 16'd8) begin
      n_fail++;
      $display("FAIL collision_data got %0d %0d %0d %0d expected 8", q_a0, q_b0, q_a1, q_b1);
    end
  endtask

  task automatic test_rdw();
    drive(1, 3, 6, 0, 0, 0);
    tick();
    drive(1, 3, 12, 0, 3, 0);
    tick();
    n_checks++;
    if (q_b0 !== 16'd6 || q_a0 !== 16'd6) begin
      n_fail++;
      $display("FAIL rdw_old got a=%0d b=%0d expected 6", q_a0, q_b0);
    end
    n_checks++;
    if (q_b1 !== 16'd12 || q_a1 !== 16'd12) begin
      n_fail++;
      $display("FAIL rdw_new got a=%0d b=%0d expected 12", q_a1, q_b1);
    end
    drive(0, 5, 0, 1, 5, 33);
    tick();
    n_checks++;
    if (q_a0 !== 16'd0 || q_a1 !== 16'd33) begin
      n_fail++;
      $display("FAIL rdw_cross got old=%0d new=%0d expected 0/33", q_a0, q_a1);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom));
      tick();
      n_checks++;
      if (q_a0 !== e_qa0 || q_b0 !== e_qb0 || q_a1 !== e_qa1 || q_b1 !== e_qb1 ||
          coll0 !== e_coll || coll1 !== e_coll || busy0 !== 1'b0 || busy1 !== 1'b0) begin
        n_fail++;
        $display("FAIL random cycle %0d got %h %h %h %h c%b%b b%b%b expected %h %h %h %h c%b b0",
                 c, q_a0, q_b0, q_a1, q_b1, coll0, coll1, busy0, busy1,
                 e_qa0, e_qb0, e_qa1, e_qb1, e_coll);
      end
    end
  endtask

  task automatic test_clear();
    int cnt;
    for (int a = 0; a < 4; a++) begin
      drive(1, a, 16'h1111 * (a + 1), 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    clear = 1'b1;
    tick();
    cnt = busy0 ? 1 : 0;
    for (int c = 0; c < 1030; c++) begin
      if (m_left > 0) begin
        drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom));
        clear = 1'($urandom_range(0, 1));
      end else begin
        drive(0, 0, 0, 0, 0, 0);
        clear = 1'b0;
      end
      tick();
      n_checks++;
      if (busy0 !== e_busy || busy1 !== e_busy || coll0 !== e_coll || coll1 !== e_coll ||
          q_a0 !== e_qa0 || q_b0 !== e_qb0 || q_a1 !== e_qa1 || q_b1 !== e_qb1) begin
        n_fail++;
        $display("FAIL clear_sweep cycle %0d got b%b%b c%b%b q %h %h %h %h expected b%b c%b q %h %h %h %h",
                 c, busy0, busy1, coll0, coll1, q_a0, q_b0, q_a1, q_b1,
                 e_busy, e_coll, e_qa0, e_qb0, e_qa1, e_qb1);
      end
      if (busy0) cnt++;
    end
    n_checks++;
    if (cnt != DEPTH) begin
      n_fail++;
      $display("FAIL clear_len got %0d expected %0d", cnt, DEPTH);
    end
    for (int k = 0; k < 12; k++) begin
      int ra = (k < 4) ? k : int'($urandom_range(0, DEPTH - 1));
      drive(0, ra, 0, 0, ra, 0);
      tick();
      n_checks++;
      if (q_a0 !== '0 || q_b1 !== '0) begin
        n_fail++;
        $display("FAIL clear_readback @%0d got %h/%h expected 0", ra, q_a0, q_b1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int low_cnt, low_idx;
    low_cnt = 0;
    low_idx = -1;
    drive(0, 0, 0, 0, 0, 0);
    clear = 1'b1;
    for (int c = 0; c < 2049; c++) begin
      tick();
      n_checks++;
      if (busy0 !== e_busy || busy1 !== e_busy) begin
        n_fail++;
        $display("FAIL b2b_busy cycle %0d got %b%b expected %b", c, busy0, busy1, e_busy);
      end
      if (!busy0) begin
        low_cnt++;
        low_idx = c;
      end
    end
    n_checks++;
    if (low_cnt != 1 || low_idx != DEPTH) begin
      n_fail++;
      $display("FAIL b2b_gap got %0d idle cycles at %0d expected 1 at %0d", low_cnt, low_idx, DEPTH);
    end
    clear = 1'b0;
    for (int c = 0; c < 1100 && m_left > 0; c++) tick();
    tick();
    n_checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end got busy=%b%b expected 00", busy0, busy1);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    drive(1, 7, 16'hBEEF, 1, 9, 16'h1234);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int c = 0; c < 499; c++) tick();
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({q_a0, q_b0, q_a1, q_b1} !== '0 || {busy0, busy1, coll0, coll1} !== 4'b0) begin
      n_fail++;
      $display("FAIL midsweep_reset got qa=%h qb=%h busy=%b%b coll=%b%b expected 0",
               q_a0, q_b0, busy0, busy1, coll0, coll1);
    end
    @(posedge clock);
    #3 reset_n = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    cnt = 0;
    for (int c = 0; c < 1030; c++) begin
      tick();
      n_checks++;
      if (busy0 !== e_busy || busy1 !== e_busy) begin
        n_fail++;
        $display("FAIL midsweep_busy cycle %0d got %b%b expected %b", c, busy0, busy1, e_busy);
      end
      if (busy0) cnt++;
    end
    n_checks++;
    if (cnt != DEPTH) begin
      n_fail++;
      $display("FAIL midsweep_len got %0d expected %0d", cnt, DEPTH);
    end
    drive(0, 7, 0, 0, 9, 0);
    tick();
    n_checks++;
    if (q_a0 !== '0 || q_b0 !== '0 || q_a0 !== e_qa0 || q_b0 !== e_qb0) begin
      n_fail++;
      $display("FAIL midsweep_readback got %h/%h expected 0", q_a0, q_b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dual_write();
    test_collision();
    test_rdw();
    test_random();
    test_clear();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_dual_port_mem.md
PARAM_DUAL_PORT_MEM -- requirements
Module: param_dual_port_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 16: word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 10: address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter RDW_MODE, default 0: read-during-write result; 0 = old data, 1 = new data.
REQ-004 SHALL have parameter CLEAR_VAL, default 0 (DATA_W bits): value written by the clear engine.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = start a clear sweep automatically on reset release.
REQ-006 SHALL have port clock  input  1: the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset_n  input  1: reset, asynchronous and active-low.
REQ-008 SHALL have port data_a / data_b  input  DATA_W each: write data for port A / port B.
REQ-009 SHALL have port address_a / address_b  input  ADDR_W each: address for port A / port B.
REQ-010 SHALL have port wren_a / wren_b  input  1 each: write enable for port A / port B.
REQ-011 SHALL have port clear  input  1: start a full-array clear sweep.
REQ-012 SHALL have port q_a / q_b  output  DATA_W each: registered read data for port A / port B.
REQ-013 SHALL have port busy  output  1: clear sweep in progress.
REQ-014 SHALL have port collision  output  1: one-cycle flag for a same-address dual write.

Function
REQ-015 Port A and port B SHALL each read every cycle: q_x = mem[address_x] sampled at edge N, valid after edge N; latency 1.
REQ-016 With wren_x=1 and busy=0, mem[address_x] SHALL take data_x at the edge.
REQ-017 If wren_a=wren_b=1 and address_a==address_b, the edge SHALL store data_a only, and collision SHALL be 1 for the following cycle; otherwise collision SHALL be 0.
REQ-018 Same-port or cross-port read of an address written at the same edge SHALL return the pre-write word when RDW_MODE=0.
REQ-019 Same-port or cross-port read of an address written at the same edge SHALL return the stored word, with port A winning collisions, when RDW_MODE=1.
REQ-020 Clear FSM states SHALL be IDLE and CLEAR.
REQ-021 Transition IDLE->CLEAR SHALL occur on clear=1; the sweep SHALL then write CLEAR_VAL to addresses 0, 1, ... 2**ADDR_W-1, one per cycle.
REQ-022 Transition CLEAR->IDLE SHALL occur after the last address is written; busy SHALL be 1 exactly 2**ADDR_W cycles.
REQ-023 While busy=1, wren_a and wren_b SHALL be ignored, collision SHALL stay 0, and q_a/q_b SHALL hold their last values.
REQ-024 clear=1 while in CLEAR SHALL be ignored; clear=1 on the cycle busy falls SHALL start a new sweep immediately.
REQ-025 Address counter SHALL be ADDR_W bits and SHALL terminate at all-ones without wrapping into a second pass.

Reset
REQ-026 reset_n=0 SHALL immediately force q_a=0, q_b=0, busy=0, collision=0, FSM=IDLE, and address counter=0.
REQ-027 Array contents SHALL NOT be altered by reset itself.
REQ-028 With CLEAR_ON_RESET=1, the first edge after reset_n rises SHALL enter CLEAR.
REQ-029 With CLEAR_ON_RESET=0, the FSM SHALL stay in IDLE after reset.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep; with CLEAR_ON_RESET=1 the sweep SHALL restart from address 0 after release.

Verification
REQ-031 Defaults, after the reset sweep: A writes 16'h000F @0, then B reads @0 -> q_b=15 one cycle after the read edge.
REQ-032 B writes 7 @1 while A writes 5 @2 in the same cycle -> reads return 7 @1 and 5 @2; collision stays 0.
REQ-033 Both ports write @4, A=8 and B=9 -> collision=1 for one cycle; later reads of @4 on both ports return 8.
REQ-034 RDW_MODE=0 and 1 runs: @3 holds 6, A writes 12 @3 while B reads @3 -> q_b=6 (mode 0) / 12 (mode 1).
REQ-035 Fill @0..@3 with nonzero words, pulse clear -> busy high 1024 cycles, writes during the sweep ignored, all addresses read 0 after.
REQ-036 Assert reset_n=0 at sweep cycle 500 -> outputs zero immediately; after release a full 1024-cycle sweep reruns.
